fft_addr_seq: RTL and testbench

- Self-sequencing radix-2 in-place FFT address sequencer with parametrised point count N and butterfly pipeline latency.
- Runs a complete transform: bit-reversed load, log2(N) butterfly stages, natural-order unload.
- Per butterfly it issues read addresses, twiddle index and delayed write-back addresses, and inserts drain gaps so stage s+1 never reads data stage s has not yet written.
- Sits between the FFT control top and the sample RAM / twiddle ROM / butterfly datapath.

---
 rtl/fft_addr_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_fft_addr_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_addr_seq.sv
// rtl/fft_addr_seq.sv - radix-2 in-place FFT address sequencer (load, butterfly stages, unload)
module fft_addr_seq #(
    parameter int N        = 8,
    parameter int BFLY_LAT = 2,
    localparam int L       = $clog2(N),
    localparam int SW      = ($clog2(L) > 1) ? $clog2(L) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_in_valid,
    output logic          o_load_ready,
    output logic [L-1:0]  o_load_addr,
    output logic          o_rd_valid,
    output logic [L-1:0]  o_rd_even_addr,
    output logic [L-1:0]  o_rd_odd_addr,
    output logic [L-2:0]  o_twi_addr,
    output logic [SW-1:0] o_stage,
    output logic          o_wr_valid,
    output logic [L-1:0]  o_wr_top_addr,
    output logic [L-1:0]  o_wr_bot_addr,
    output logic          o_unload_valid,
    output logic [L-1:0]  o_unload_addr,
    input  logic          i_out_ready,
    output logic          o_busy,
    output logic          o_done
);

    localparam int DW = ($clog2(BFLY_LAT + 1) > 1) ? $clog2(BFLY_LAT + 1) : 1;

    localparam logic [L-1:0]  K_LAST = L'(N - 1);
    localparam logic [L-2:0]  P_LAST = (L-1)'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(L - 1);
    localparam logic [DW-1:0] D_LAST = DW'(BFLY_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [L-1:0]  r_k, w_k_nxt;
    logic [SW-1:0] r_s, w_s_nxt;
    logic [L-2:0]  r_p, w_p_nxt;
    logic [DW-1:0] r_d, w_d_nxt;

    logic [L-1:0]   w_bitrev;
    logic [L-1:0]   w_pair_even, w_pair_odd;
    logic [2*L-1:0] w_even_sh, w_odd_sh;
    logic [L-1:0]   w_even_rot, w_odd_rot;
    logic [L-2:0]   w_twi_mask;
    logic           w_rd_valid;
    logic [L-1:0]   w_rd_even, w_rd_odd;

    logic [BFLY_LAT-1:0] r_pipe_v;
    logic [L-1:0]        r_pipe_e [BFLY_LAT];
    logic [L-1:0]        r_pipe_o [BFLY_LAT];

    // State and counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_s     <= '0;
            r_p     <= '0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_s     <= w_s_nxt;
            r_p     <= w_p_nxt;
            r_d     <= w_d_nxt;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_s_nxt     = r_s;
        w_p_nxt     = r_p;
        w_d_nxt     = r_d;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                    w_k_nxt     = '0;
                end
            end
            S_LOAD: begin
                if (i_in_valid) begin
                    if (r_k == K_LAST) begin
                        w_state_nxt = S_RUN;
                        w_k_nxt     = '0;
                        w_s_nxt     = '0;
                        w_p_nxt     = '0;
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (r_p == P_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_p_nxt     = '0;
                    w_d_nxt     = '0;
                end else begin
                    w_p_nxt = r_p + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_d == D_LAST) begin
                    if (r_s == S_LAST) begin
                        w_state_nxt = S_UNLOAD;
                        w_k_nxt     = '0;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_s_nxt     = r_s + 1'b1;
                    end
                end else begin
                    w_d_nxt = r_d + 1'b1;
                end
            end
            S_UNLOAD: begin
                if (i_out_ready) begin
                    if (r_k == K_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
                w_s_nxt     = '0;
                w_p_nxt     = '0;
                w_d_nxt     = '0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address arithmetic: bit-reversed load index, rotated butterfly pair, twiddle mask
    always_comb begin
        w_bitrev = '0;
        for (int i = 0; i < L; i++) begin
            w_bitrev[i] = r_k[L-1-i];
        end
        w_pair_even = {r_p, 1'b0};
        w_pair_odd  = {r_p, 1'b1};
        w_even_sh   = {{L{1'b0}}, w_pair_even} << r_s;
        w_odd_sh    = {{L{1'b0}}, w_pair_odd} << r_s;
        w_even_rot  = w_even_sh[L-1:0] | w_even_sh[2*L-1:L];
        w_odd_rot   = w_odd_sh[L-1:0] | w_odd_sh[2*L-1:L];
        w_twi_mask  = {(L-1){1'b1}} << (S_LAST - r_s);
    end

    // State-owned outputs; everything outside its owning state reads as zero
    always_comb begin
        o_load_ready   = 1'b0;
        o_load_addr    = '0;
        w_rd_valid     = 1'b0;
        w_rd_even      = '0;
        w_rd_odd       = '0;
        o_twi_addr     = '0;
        o_stage        = '0;
        o_unload_valid = 1'b0;
        o_unload_addr  = '0;
        o_busy         = (r_state != S_IDLE);
        o_done         = (r_state == S_DONE);
        case (r_state)
            S_LOAD: begin
                o_load_ready = 1'b1;
                o_load_addr  = w_bitrev;
            end
            S_RUN: begin
                w_rd_valid = 1'b1;
                w_rd_even  = w_even_rot;
                w_rd_odd   = w_odd_rot;
                o_twi_addr = r_p & w_twi_mask;
                o_stage    = r_s;
            end
            S_UNLOAD: begin
                o_unload_valid = 1'b1;
                o_unload_addr  = r_k;
            end
            default: ;
        endcase
    end

    assign o_rd_valid     = w_rd_valid;
    assign o_rd_even_addr = w_rd_even;
    assign o_rd_odd_addr  = w_rd_odd;

    // Write-back delay line: reads reappear as writes BFLY_LAT cycles later
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pipe_v <= '0;
            for (int i = 0; i < BFLY_LAT; i++) begin
                r_pipe_e[i] <= '0;
                r_pipe_o[i] <= '0;
            end
        end else begin
            r_pipe_v[0] <= w_rd_valid;
            r_pipe_e[0] <= w_rd_even;
            r_pipe_o[0] <= w_rd_odd;
            for (int i = 1; i < BFLY_LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_e[i] <= r_pipe_e[i-1];
                r_pipe_o[i] <= r_pipe_o[i-1];
            end
        end
    end

    assign o_wr_valid    = r_pipe_v[BFLY_LAT-1];
    assign o_wr_top_addr = r_pipe_e[BFLY_LAT-1];
    assign o_wr_bot_addr = r_pipe_o[BFLY_LAT-1];

endmodule

// File: tb/tb_fft_addr_seq.sv
// tb/tb_fft_addr_seq.sv - randomized self-checking bench for fft_addr_seq (N=8/LAT=2 and N=16/LAT=1)
module tb_fft_addr_seq;

    typedef struct {
        int lr, la, rv, re, ro, tw, st, wv, wt, wb, uv, ua, busy, done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [2];
    logic start [2];
    logic in_valid [2];
    logic out_ready [2];

    int o_lr [2], o_la [2], o_rv [2], o_re [2], o_ro [2], o_tw [2], o_st [2];
    int o_wv [2], o_wt [2], o_wb [2], o_uv [2], o_ua [2], o_busy [2], o_done [2];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int GN = (g == 0) ? 8 : 16;
        localparam int GB = (g == 0) ? 2 : 1;
        localparam int GL = $clog2(GN);
        localparam int GS = ($clog2(GL) > 1) ? $clog2(GL) : 1;
        logic          lr, rv, wv, uv, busy, done;
        logic [GL-1:0] la, re, ro, wt, wb, ua;
        logic [GL-2:0] tw;
        logic [GS-1:0] st;

        fft_addr_seq #(.N(GN), .BFLY_LAT(GB)) u_dut (
            .i_clk         (clk),
            .i_rst         (rst[g]),
            .i_start       (start[g]),
            .i_in_valid    (in_valid[g]),
            .o_load_ready  (lr),
            .o_load_addr   (la),
            .o_rd_valid    (rv),
            .o_rd_even_addr(re),
            .o_rd_odd_addr (ro),
            .o_twi_addr    (tw),
            .o_stage       (st),
            .o_wr_valid    (wv),
            .o_wr_top_addr (wt),
            .o_wr_bot_addr (wb),
            .o_unload_valid(uv),
            .o_unload_addr (ua),
            .i_out_ready   (out_ready[g]),
            .o_busy        (busy),
            .o_done        (done)
        );

        assign o_lr[g]   = int'(lr);
        assign o_la[g]   = int'(la);
        assign o_rv[g]   = int'(rv);
        assign o_re[g]   = int'(re);
        assign o_ro[g]   = int'(ro);
        assign o_tw[g]   = int'(tw);
        assign o_st[g]   = int'(st);
        assign o_wv[g]   = int'(wv);
        assign o_wt[g]   = int'(wt);
        assign o_wb[g]   = int'(wb);
        assign o_uv[g]   = int'(uv);
        assign o_ua[g]   = int'(ua);
        assign o_busy[g] = int'(busy);
        assign o_done[g] = int'(done);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t blank();
        exp_t z;
        z = '{default: 0};
        return z;
    endfunction

    function automatic int bitrev(input int x, input int l);
        int r = 0;
        for (int i = 0; i < l; i++) r = (r << 1) | ((x >> i) & 1);
        return r;
    endfunction

    function automatic int rotl(input int x, input int s, input int l);
        return ((x << s) | (x >> (l - s))) & ((1 << l) - 1);
    endfunction

    function automatic int twiddle(input int p, input int s, input int l);
        return (p >> (l - 1 - s)) << (l - 1 - s);
    endfunction

    function automatic logic pick(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic compare(input int g, input exp_t e);
        chk($sformatf("i%0d load_ready", g), o_lr[g], e.lr);
        chk($sformatf("i%0d load_addr", g), o_la[g], e.la);
        chk($sformatf("i%0d rd_valid", g), o_rv[g], e.rv);
        chk($sformatf("i%0d rd_even", g), o_re[g], e.re);
        chk($sformatf("i%0d rd_odd", g), o_ro[g], e.ro);
        chk($sformatf("i%0d twi", g), o_tw[g], e.tw);
        chk($sformatf("i%0d stage", g), o_st[g], e.st);
        chk($sformatf("i%0d wr_valid", g), o_wv[g], e.wv);
        chk($sformatf("i%0d wr_top", g), o_wt[g], e.wt);
        chk($sformatf("i%0d wr_bot", g), o_wb[g], e.wb);
        chk($sformatf("i%0d unload_valid", g), o_uv[g], e.uv);
        chk($sformatf("i%0d unload_addr", g), o_ua[g], e.ua);
        chk($sformatf("i%0d busy", g), o_busy[g], e.busy);
        chk($sformatf("i%0d done", g), o_done[g], e.done);
    endtask

    // Full transform on instance g. mode: 0 no stall, 1 alternating 1-0, 2 random.
    task automatic run_transform(input int g, input int mode, input bit busy_start);
        int n, l, bl, hs, guard, cyc;
        logic hsk;
        exp_t e;
        exp_t rd [$];
        n  = (g == 0) ? 8 : 16;
        bl = (g == 0) ? 2 : 1;
        l  = $clog2(n);
        for (int s = 0; s < l; s++) begin
            for (int p = 0; p < n / 2; p++) begin
                e = blank();
                e.rv = 1;
                e.re = rotl(2 * p, s, l);
                e.ro = rotl(2 * p + 1, s, l);
                e.tw = twiddle(p, s, l);
                e.st = s;
                rd.push_back(e);
            end
            for (int d = 0; d < bl; d++) rd.push_back(blank());
        end

        @(negedge clk);
        compare(g, blank());
        start[g]    = 1'b1;
        in_valid[g] = 1'b0;
        @(negedge clk);
        cyc = 0;

        hs = 0;
        guard = 0;
        while (hs < n && guard < 400) begin
            e = blank();
            e.busy = 1;
            e.lr   = 1;
            e.la   = bitrev(hs, l);
            compare(g, e);
            start[g]     = busy_start ? 1'($urandom_range(0, 1)) : 1'b0;
            hsk          = pick(mode, guard);
            in_valid[g]  = hsk;
            out_ready[g] = 1'($urandom_range(0, 1));
            if (hsk) hs++;
            cyc++;
            guard++;
            @(negedge clk);
        end
        if (hs < n) chk($sformatf("i%0d load timeout", g), hs, n);

        for (int t = 0; t < rd.size(); t++) begin
            e = rd[t];
            e.busy = 1;
            if (t >= bl) begin
                e.wv = rd[t-bl].rv;
                e.wt = rd[t-bl].re;
                e.wb = rd[t-bl].ro;
            end
            compare(g, e);
            start[g]     = busy_start ? 1'($urandom_range(0, 1)) : 1'b0;
            in_valid[g]  = 1'($urandom_range(0, 1));
            out_ready[g] = 1'($urandom_range(0, 1));
            cyc++;
            @(negedge clk);
        end

        hs = 0;
        guard = 0;
        while (hs < n && guard < 400) begin
            e = blank();
            e.busy = 1;
            e.uv   = 1;
            e.ua   = hs;
            compare(g, e);
            start[g]     = busy_start ? 1'($urandom_range(0, 1)) : 1'b0;
            in_valid[g]  = 1'($urandom_range(0, 1));
            hsk          = pick(mode, guard);
            out_ready[g] = hsk;
            if (hsk) hs++;
            cyc++;
            guard++;
            @(negedge clk);
        end
        if (hs < n) chk($sformatf("i%0d unload timeout", g), hs, n);

        e = blank();
        e.busy = 1;
        e.done = 1;
        compare(g, e);
        cyc++;
        @(negedge clk);
        start[g]    = 1'b0;
        in_valid[g] = 1'b0;
        compare(g, blank());
        if (mode == 0) chk($sformatf("i%0d cycles", g), cyc, 2 * n + l * (n / 2 + bl) + 1);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst[g]       = 1'b1;
            start[g]     = 1'b0;
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b0;
        end
        repeat (2) @(negedge clk);
        compare(0, blank());
        compare(1, blank());
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        run_transform(0, 0, 1'b0);
        run_transform(0, 1, 1'b0);
        run_transform(0, 2, 1'b0);

        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0]    = 1'b0;
        in_valid[0] = 1'b1;
        repeat (8) @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("i0 pre-reset rd_valid", o_rv[0], 1);
        rst[0] = 1'b1;
        #1;
        compare(0, blank());
        @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        compare(0, blank());
        run_transform(0, 0, 1'b0);

        run_transform(1, 0, 1'b1);
        run_transform(1, 2, 1'b0);
        run_transform(1, 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
